// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IFU and LSU.
// Data-first arbitration with a fetch starvation guard and a busy watchdog.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  output logic        i_error,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_error,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  input  logic        m_error,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  streak, streak_nx;
  logic [15:0] wd;
  logic        busy, tmo, done;
  logic        grant_i, grant_d;

  always_comb begin
    busy    = state != IDLE;
    tmo     = (TIMEOUT != 0) && busy && !m_ready
              && (wd == 16'(TIMEOUT));
    done    = busy && (m_ready || tmo);
    grant_d = !busy && d_req
              && (!i_req || streak < 4'(MAX_D_STREAK));
    grant_i = !busy && i_req && !grant_d;
  end

  always_comb begin
    state_nx  = state;
    streak_nx = streak;
    unique case (1'b1)
      grant_d: begin
        state_nx  = BUSY_D;
        streak_nx = i_req ? streak + 4'd1 : 4'd0;
      end
      grant_i: begin
        state_nx  = BUSY_I;
        streak_nx = '0;
      end
      done:    state_nx = IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      streak <= '0;
      wd     <= '0;
    end else begin
      state  <= state_nx;
      streak <= streak_nx;
      wd     <= (busy && !done) ? wd + 16'd1 : 16'd0;
    end
  end

  // request bundle is captured once at grant and frozen while busy
  always_ff @(posedge clk) begin
    if (rst || done) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
    end else if (grant_d) begin
      m_req   <= 1'b1;
      m_we    <= d_we;
      m_addr  <= d_addr;
      m_wdata <= d_we ? d_wdata : 32'd0;
      m_wstrb <= d_wstrb;
    end else if (grant_i) begin
      m_req   <= 1'b1;
      m_we    <= 1'b0;
      m_addr  <= i_addr;
      m_wdata <= '0;
      m_wstrb <= '0;
    end
  end

  always_comb begin
    owner   = state;
    i_ready = done && (state == BUSY_I);
    d_ready = done && (state == BUSY_D);
    i_error = i_ready && (m_error || !m_ready);
    d_error = d_ready && (m_error || !m_ready);
    i_rdata = (state == BUSY_I && m_ready) ? m_rdata : 32'd0;
    d_rdata = (state == BUSY_D && m_ready) ? m_rdata : 32'd0;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && !busy && m_ready)
      $warning("mem_port_arbiter: spurious m_ready in IDLE");
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus, transaction-level model
// checked every cycle, plus literal expectations per scenario.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic        clk = 0, rst = 1;
  logic        i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic [3:0]  d_wstrb = 0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ready, i_error, d_ready, d_error;
  logic        m_req, m_we;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata = 0;
  logic        m_ready = 0, m_error = 0;
  logic [1:0]  owner;

  mem_port_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_ready(i_ready), .i_error(i_error),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rdata(d_rdata),
    .d_ready(d_ready), .d_error(d_error),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .m_ready(m_ready), .m_error(m_error), .owner(owner)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  s;
  } dop_t;

  logic [31:0] fq[$];
  dop_t        dq[$];

  // requesters: hold the head request until its ready pulse
  initial forever begin
    logic fi, fd;
    @(negedge clk);
    fi = i_ready;
    fd = d_ready;
    @(posedge clk); #1;
    if (fi && fq.size() > 0) void'(fq.pop_front());
    if (fd && dq.size() > 0) void'(dq.pop_front());
    i_req  = fq.size() > 0;
    i_addr = fq.size() > 0 ? fq[0] : 32'd0;
    d_req  = dq.size() > 0;
    if (dq.size() > 0) begin
      d_we = dq[0].we; d_addr = dq[0].a;
      d_wdata = dq[0].wd; d_wstrb = dq[0].s;
    end else begin
      d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    end
  end

  // memory: responds on the mem_lat-th cycle of an outstanding request
  int          mem_lat = 3;
  logic [31:0] mem_data = 32'h13;
  bit          mem_err = 0, mem_hang = 0;
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      cnt     = m_req ? cnt + 1 : 0;
      m_ready = m_req && !mem_hang && cnt == mem_lat;
      m_rdata = m_ready ? mem_data : 32'd0;
      m_error = m_ready && mem_err;
    end
  end

  // model: one outstanding transaction, age in busy cycles
  bit          mv = 0, mb = 0, mw = 0;
  int          age = 0, dstreak = 0;
  bit          t_we;
  logic [31:0] t_a, t_wd;
  logic [3:0]  t_s;

  always @(negedge clk) begin
    bit fin, ri, rd;
    fin = mb && (m_ready || (TMO != 0 && age == TMO));
    ri  = fin && !mw;
    rd  = fin && mw;
    if (mv) begin
      chk("m_req", m_req, mb);
      chk("owner", owner, mb ? (mw ? 2 : 1) : 0);
      if (mb) begin
        chk("m_we", m_we, t_we);
        chk("m_addr", m_addr, t_a);
        chk("m_wdata", m_wdata, t_wd);
        chk("m_wstrb", m_wstrb, t_s);
      end
      chk("i_ready", i_ready, ri);
      chk("i_error", i_error, ri && (!m_ready || m_error));
      chk("i_rdata", i_rdata, (mb && !mw && m_ready) ? m_rdata : 0);
      chk("d_ready", d_ready, rd);
      chk("d_error", d_error, rd && (!m_ready || m_error));
      chk("d_rdata", d_rdata, (mb && mw && m_ready) ? m_rdata : 0);
    end
    if (rst) begin
      mv = 1; mb = 0; age = 0; dstreak = 0;
    end else if (mb) begin
      if (fin) mb = 0;
      else age++;
    end else if (d_req && (!i_req || dstreak < MAXS)) begin
      mb = 1; mw = 1; age = 0;
      dstreak = i_req ? dstreak + 1 : 0;
      t_we = d_we; t_a = d_addr;
      t_wd = d_we ? d_wdata : 0; t_s = d_wstrb;
    end else if (i_req) begin
      mb = 1; mw = 0; age = 0; dstreak = 0;
      t_we = 0; t_a = i_addr; t_wd = 0; t_s = 0;
    end
  end

  int   grant_log[$];
  logic [1:0] prev_owner = 0;
  always @(negedge clk) begin
    if (!rst && owner != 0 && prev_owner == 0)
      grant_log.push_back(int'(owner));
    prev_owner = owner;
  end

  task automatic wait_rdy(input bit d, output int n);
    logic r;
    r = 0;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      n++;
      r = d ? d_ready : i_ready;
      if (r) break;
    end
    chk(d ? "wait_d_ready" : "wait_i_ready", r, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int exp_g[7] = '{2, 2, 2, 2, 1, 2, 2};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_m_req", m_req, 0);
    chk("rst_owner", owner, 0);
    chk("rst_i_ready", i_ready, 0);

    // single fetch
    fq.push_back(32'h100);
    @(negedge clk);
    chk("fetch_m_req_lat0", m_req, 0);
    @(negedge clk);
    chk("fetch_m_req_lat1", m_req, 1);
    chk("fetch_m_addr", m_addr, 32'h100);
    chk("fetch_m_wstrb", m_wstrb, 0);
    chk("fetch_owner", owner, 1);
    wait_rdy(0, n);
    chk("fetch_busy_cycles", n + 1, 3);
    chk("fetch_rdata", i_rdata, 32'h13);
    @(negedge clk);
    chk("fetch_owner_idle", owner, 0);

    // simultaneous: data write first, fetch after one bubble
    dq.push_back('{1'b1, 32'h2000, 32'hDEADBEEF, 4'hF});
    fq.push_back(32'h104);
    repeat (2) @(negedge clk);
    chk("sim_owner_d", owner, 2);
    chk("sim_m_we", m_we, 1);
    chk("sim_m_addr", m_addr, 32'h2000);
    chk("sim_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("sim_m_wstrb", m_wstrb, 4'hF);
    wait_rdy(1, n);
    @(negedge clk);
    chk("sim_bubble", owner, 0);
    @(negedge clk);
    chk("sim_owner_i", owner, 1);
    chk("sim_i_addr", m_addr, 32'h104);
    wait_rdy(0, n);
    @(negedge clk);

    // starvation guard
    grant_log.delete();
    for (int k = 0; k < 6; k++)
      dq.push_back('{1'b0, 32'h3000 + 32'(4 * k), 32'd0, 4'd0});
    fq.push_back(32'h200);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (fq.size() == 0 && dq.size() == 0) break;
    end
    repeat (2) @(negedge clk);
    chk("starve_count", grant_log.size(), 7);
    for (int i = 0; i < 7; i++)
      chk("starve_grant",
          i < grant_log.size() ? grant_log[i] : 0, exp_g[i]);

    // error routing
    mem_err = 1;
    dq.push_back('{1'b0, 32'hFFFF0000, 32'd0, 4'd0});
    wait_rdy(1, n);
    chk("err_d_ready", d_ready, 1);
    chk("err_d_error", d_error, 1);
    chk("err_i_ready", i_ready, 0);
    chk("err_i_error", i_error, 0);
    mem_err = 0;
    @(negedge clk);

    // watchdog
    mem_hang = 1;
    fq.push_back(32'h300);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_req) break;
    end
    chk("wd_m_req", m_req, 1);
    wait_rdy(0, n);
    chk("wd_delay", n, TMO);
    chk("wd_i_error", i_error, 1);
    chk("wd_i_rdata", i_rdata, 0);
    @(negedge clk);
    chk("wd_m_req_low", m_req, 0);
    chk("wd_owner_idle", owner, 0);

    // reset while busy on data
    dq.push_back('{1'b0, 32'h4000, 32'd0, 4'd0});
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (owner == 2) break;
    end
    chk("mrst_busy_d", owner, 2);
    dq.delete();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("mrst_m_req", m_req, 0);
    chk("mrst_owner", owner, 0);
    chk("mrst_m_addr", m_addr, 0);
    chk("mrst_d_ready", d_ready, 0);
    mem_hang = 0;
    fq.push_back(32'h400);
    wait_rdy(0, n);
    chk("mrst_fetch_rdata", i_rdata, 32'h13);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
